alu_acc: RTL and testbench

Parametrised accumulator ALU, successor to the 8-bit combinational ALU. It holds the accumulator internally and executes one opcode per accepted request using a valid/ready handshake. It adds carry-chained arithmetic, status flags, an optional saturating mode, and multi-cycle iterative shifts. It sits between the instruction decoder (request side) and the register/write-back path (result side).

---
 rtl/alu_acc.sv | 157 +++++++++++++++
 tb/tb_alu_acc.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_acc.sv
// Accumulator ALU: one opcode per accepted request, carry-chained arithmetic,
// status flags, optional unsigned saturation and bit-serial multi-cycle shifts.
module alu_acc #(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] data,
  output logic             out_valid,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_OR   = 4'h1;
  localparam logic [3:0] OP_NOT  = 4'h2;
  localparam logic [3:0] OP_XOR  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_LOAD = 4'h7;
  localparam logic [3:0] OP_ADC  = 4'h8;
  localparam logic [3:0] OP_SBB  = 4'h9;
  localparam logic [3:0] OP_SHL  = 4'hA;
  localparam logic [3:0] OP_SHR  = 4'hB;
  localparam logic [3:0] OP_ROL  = 4'hC;
  localparam logic [3:0] OP_CLR  = 4'hD;

  typedef enum logic [0:0] {IDLE, SHIFT} state_t;

  // Handshake: a request is taken on a rising edge with in_valid && in_ready;
  // in_ready is high only in IDLE. out_valid is a single-cycle pulse in the
  // cycle after each completion and carries no backpressure.
  state_t           state;
  logic [WIDTH-1:0] acc;
  logic             carry_q;
  logic             ovf_q;
  logic             out_valid_q;
  logic [SHW-1:0]   cnt;
  logic [3:0]       sh_op;

  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic             add_ovf;
  logic             sub_ovf;
  logic [WIDTH-1:0] nxt_acc;
  logic             nxt_c;
  logic             nxt_v;
  logic [SHW-1:0]   shift_n;
  logic             start_shift;
  logic [WIDTH-1:0] step_acc;
  logic             step_c;

  assign shift_n     = data[SHW-1:0];
  assign start_shift = ((opcode == OP_SHL) || (opcode == OP_SHR) || (opcode == OP_ROL))
                       && (shift_n != '0);

  always_comb begin
    cin     = carry_q & ((opcode == OP_ADC) || (opcode == OP_SBB));
    sum     = {1'b0, acc} + {1'b0, data} + {{WIDTH{1'b0}}, cin};
    dif     = {1'b0, acc} - {1'b0, data} - {{WIDTH{1'b0}}, cin};
    add_ovf = (acc[WIDTH-1] == data[WIDTH-1]) && (sum[WIDTH-1] != acc[WIDTH-1]);
    sub_ovf = (acc[WIDTH-1] != data[WIDTH-1]) && (dif[WIDTH-1] != acc[WIDTH-1]);
    nxt_acc = acc;
    nxt_c   = carry_q;
    nxt_v   = ovf_q;
    case (opcode)
      OP_AND:  begin nxt_acc = acc & data; nxt_v = 1'b0; end
      OP_OR:   begin nxt_acc = acc | data; nxt_v = 1'b0; end
      OP_NOT:  begin nxt_acc = ~acc;       nxt_v = 1'b0; end
      OP_XOR:  begin nxt_acc = acc ^ data; nxt_v = 1'b0; end
      OP_LOAD: begin nxt_acc = data;       nxt_v = 1'b0; end
      OP_CLR:  begin nxt_acc = '0;         nxt_v = 1'b0; end
      OP_ADD, OP_ADC: begin
        // Flags always reflect the unclamped result, even when saturating.
        nxt_acc = ((SATURATE != 0) && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
        nxt_c   = sum[WIDTH];
        nxt_v   = add_ovf;
      end
      OP_SUB, OP_SBB: begin
        nxt_acc = ((SATURATE != 0) && dif[WIDTH]) ? '0 : dif[WIDTH-1:0];
        nxt_c   = dif[WIDTH];
        nxt_v   = sub_ovf;
      end
      default: ;
    endcase
  end

  always_comb begin
    step_acc = {acc[WIDTH-2:0], acc[WIDTH-1]};
    step_c   = acc[WIDTH-1];
    case (sh_op)
      OP_SHL:  begin step_acc = {acc[WIDTH-2:0], 1'b0}; step_c = acc[WIDTH-1]; end
      OP_SHR:  begin step_acc = {1'b0, acc[WIDTH-1:1]}; step_c = acc[0];       end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      cnt         <= '0;
      sh_op       <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (start_shift) begin
              state <= SHIFT;
              cnt   <= shift_n;
              sh_op <= opcode;
            end else begin
              acc         <= nxt_acc;
              carry_q     <= nxt_c;
              ovf_q       <= nxt_v;
              out_valid_q <= 1'b1;
            end
          end
        end
        SHIFT: begin
          // One bit per edge; the final step completes the operation.
          acc     <= step_acc;
          carry_q <= step_c;
          cnt     <= cnt - 1'b1;
          if (cnt == SHW'(1)) begin
            state       <= IDLE;
            out_valid_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = out_valid_q;
  assign alu_out   = acc;
  assign zero      = (acc == '0);
  assign negative  = acc[WIDTH-1];
  assign carry     = carry_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu_acc.sv
// Bench for alu_acc: table of single-cycle vectors issued back-to-back on a
// plain and a saturating instance, then directed shift and reset sequences.
module tb_alu_acc;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] opcode;
  logic [7:0] data;

  logic       in_ready, out_valid, zero, negative, carry, overflow;
  logic [7:0] alu_out;
  logic       s_in_ready, s_out_valid, s_zero, s_negative, s_carry, s_overflow;
  logic [7:0] s_alu_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] op;
    logic [7:0] d;
    logic [7:0] a;
    logic       c;
    logic       v;
    logic [7:0] sa;
    logic       sc;
    logic       sv;
  } vec_t;

  vec_t vq[$];

  alu_acc #(.WIDTH(8), .SATURATE(0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .data(data), .out_valid(out_valid), .alu_out(alu_out),
    .zero(zero), .negative(negative), .carry(carry), .overflow(overflow)
  );

  alu_acc #(.WIDTH(8), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .opcode(opcode), .data(data), .out_valid(s_out_valid), .alu_out(s_alu_out),
    .zero(s_zero), .negative(s_negative), .carry(s_carry), .overflow(s_overflow)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add_vec(input logic [3:0] op, input logic [7:0] d,
                         input logic [7:0] a, input logic c, input logic v,
                         input logic [7:0] sa, input logic sc, input logic sv);
    vec_t t;
    t.op = op; t.d = d; t.a = a; t.c = c; t.v = v; t.sa = sa; t.sc = sc; t.sv = sv;
    vq.push_back(t);
  endtask

  // Driver: issue one request and wait (bounded) for its completion pulse.
  task automatic do_op(input logic [3:0] op, input logic [7:0] d);
    @(negedge clk);
    in_valid = 1'b1; opcode = op; data = d;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 40 && !out_valid; k++) @(negedge clk);
    chk($sformatf("do_op %0h done", op), out_valid, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; opcode = 4'h0; data = 8'h00;

    //             op    d      a     c  v    sa    sc v
    add_vec(4'h7, 8'h0F, 8'h0F, 0, 0, 8'h0F, 0, 0);  // LOAD
    add_vec(4'h0, 8'hF0, 8'h00, 0, 0, 8'h00, 0, 0);  // AND
    add_vec(4'h7, 8'h0F, 8'h0F, 0, 0, 8'h0F, 0, 0);
    add_vec(4'h1, 8'hF0, 8'hFF, 0, 0, 8'hFF, 0, 0);  // OR
    add_vec(4'h3, 8'hFF, 8'h00, 0, 0, 8'h00, 0, 0);  // XOR
    add_vec(4'h7, 8'h0F, 8'h0F, 0, 0, 8'h0F, 0, 0);
    add_vec(4'h2, 8'h00, 8'hF0, 0, 0, 8'hF0, 0, 0);  // NOT
    add_vec(4'h7, 8'hF0, 8'hF0, 0, 0, 8'hF0, 0, 0);
    add_vec(4'h4, 8'h20, 8'h10, 1, 0, 8'hFF, 1, 0);  // ADD carry out
    add_vec(4'h8, 8'h00, 8'h11, 0, 0, 8'hFF, 1, 0);  // ADC
    add_vec(4'h7, 8'h7F, 8'h7F, 0, 0, 8'h7F, 1, 0);  // LOAD keeps carry
    add_vec(4'h4, 8'h01, 8'h80, 0, 1, 8'h80, 0, 1);  // ADD signed overflow
    add_vec(4'h6, 8'h33, 8'h80, 0, 1, 8'h80, 0, 1);  // PASS
    add_vec(4'h7, 8'h0F, 8'h0F, 0, 0, 8'h0F, 0, 0);
    add_vec(4'h5, 8'hF0, 8'h1F, 1, 0, 8'h00, 1, 0);  // SUB borrow
    add_vec(4'h9, 8'h00, 8'h1E, 0, 0, 8'h00, 1, 0);  // SBB
    add_vec(4'hF, 8'h55, 8'h1E, 0, 0, 8'h00, 1, 0);  // NOP
    add_vec(4'hD, 8'h00, 8'h00, 0, 0, 8'h00, 1, 0);  // CLR
    add_vec(4'h7, 8'h81, 8'h81, 0, 0, 8'h81, 1, 0);
    add_vec(4'hA, 8'h00, 8'h81, 0, 0, 8'h81, 1, 0);  // SHL n=0
    add_vec(4'h7, 8'h80, 8'h80, 0, 0, 8'h80, 1, 0);
    add_vec(4'h5, 8'h01, 8'h7F, 0, 1, 8'h7F, 0, 1);  // SUB signed overflow
    add_vec(4'h1, 8'h00, 8'h7F, 0, 0, 8'h7F, 0, 0);  // OR clears overflow

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset alu_out", alu_out, 8'h00);
    chk("reset zero", zero, 1);
    chk("reset negative", negative, 0);
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset carry", carry, 0);
    chk("reset overflow", overflow, 0);

    // Table: back-to-back issue, one result per cycle.
    in_valid = 1'b1; opcode = vq[0].op; data = vq[0].d;
    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d out_valid", i), out_valid, 1);
      chk($sformatf("v%0d in_ready", i), in_ready, 1);
      chk($sformatf("v%0d alu_out", i), alu_out, vq[i].a);
      chk($sformatf("v%0d carry", i), carry, vq[i].c);
      chk($sformatf("v%0d overflow", i), overflow, vq[i].v);
      chk($sformatf("v%0d zero", i), zero, (vq[i].a == 8'h00));
      chk($sformatf("v%0d negative", i), negative, vq[i].a[7]);
      chk($sformatf("v%0d sat alu_out", i), s_alu_out, vq[i].sa);
      chk($sformatf("v%0d sat carry", i), s_carry, vq[i].sc);
      chk($sformatf("v%0d sat overflow", i), s_overflow, vq[i].sv);
      chk($sformatf("v%0d sat out_valid", i), s_out_valid, 1);
      if (i + 1 < vq.size()) begin
        opcode = vq[i+1].op; data = vq[i+1].d;
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("table idle out_valid", out_valid, 0);
    chk("table idle sat out_valid", s_out_valid, 0);

    // SHL 0x81 by 3, with a competing request held while busy.
    do_op(4'h7, 8'h81);
    @(negedge clk);
    in_valid = 1'b1; opcode = 4'hA; data = 8'h03;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) begin opcode = 4'h7; data = 8'h55; end
      chk($sformatf("shl busy%0d in_ready", k), in_ready, 0);
      chk($sformatf("shl busy%0d out_valid", k), out_valid, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("shl done out_valid", out_valid, 1);
    chk("shl done in_ready", in_ready, 1);
    chk("shl alu_out", alu_out, 8'h08);
    chk("shl carry", carry, 0);
    @(negedge clk);
    chk("shl pulse width", out_valid, 0);
    chk("shl busy request ignored", alu_out, 8'h08);

    // ROL 0x81 by 1.
    do_op(4'h7, 8'h81);
    @(negedge clk);
    in_valid = 1'b1; opcode = 4'hC; data = 8'h01;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("rol busy in_ready", in_ready, 0);
    chk("rol busy out_valid", out_valid, 0);
    @(negedge clk);
    chk("rol out_valid", out_valid, 1);
    chk("rol alu_out", alu_out, 8'h03);
    chk("rol carry", carry, 1);

    // SHR 0x02 by 1 clears carry.
    do_op(4'h7, 8'h02);
    do_op(4'hB, 8'h01);
    chk("shr alu_out", alu_out, 8'h01);
    chk("shr carry", carry, 0);

    // Reset two edges into SHR by 7.
    do_op(4'h7, 8'hFF);
    @(negedge clk);
    in_valid = 1'b1; opcode = 4'hB; data = 8'h07;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("shr7 step1 alu_out", alu_out, 8'h7F);
    @(negedge clk);
    chk("shr7 step2 alu_out", alu_out, 8'h3F);
    chk("shr7 step2 carry", carry, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort alu_out", alu_out, 8'h00);
    chk("abort in_ready", in_ready, 1);
    chk("abort out_valid", out_valid, 0);
    chk("abort carry", carry, 0);
    chk("abort zero", zero, 1);
    begin
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (out_valid) seen = 1'b1;
      end
      chk("abort no out_valid", seen, 0);
    end
    do_op(4'h7, 8'h5A);
    chk("after abort alu_out", alu_out, 8'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
